lif_step_scheduler: RTL and testbench

LIF_STEP_SCHEDULER -- requirements
Module: lif_step_scheduler

---
 rtl/lif_step_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_lif_step_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_step_scheduler.sv
// LIF timestep scheduler: drains the input spike FIFO into
// weight accumulation, then leaks/fires every neuron once.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 begin one timestep (sampled in IDLE only)
//   in_empty_i, in_data_i   input spike FIFO status / FWFT head
//   in_rd_o                 pop the input FIFO
//   w_addr_o, n_addr_o      weight / membrane memory addresses
//   acc_en_o, leak_en_o     datapath accumulate / leak strobes
//   fire_i                  threshold result for n_addr_o (LEAK)
//   out_full_i              output spike FIFO full
//   out_push_o, out_data_o  output spike push / neuron index
//   busy_o, step_done_o     activity flag / end-of-step pulse
//   state_o                 IDLE=0 FETCH=1 ACCUM=2 LEAK=3 DONE=4
//   step_cnt_o              completed timesteps, wrapping
//   spike_cnt_o             output spikes in current/last step
//   drop_cnt_o              dropped out-of-range inputs, saturating
module lif_step_scheduler #(
  parameter int N_PRE  = 16,
  parameter int N_POST = 10,
  parameter int STEP_W = 16,
  localparam int PRE_W  = $clog2(N_PRE),
  localparam int POST_W = $clog2(N_POST),
  localparam int WA_W   = $clog2(N_PRE * N_POST)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_empty_i,
  input  logic [PRE_W-1:0]  in_data_i,
  output logic              in_rd_o,
  output logic [WA_W-1:0]   w_addr_o,
  output logic [POST_W-1:0] n_addr_o,
  output logic              acc_en_o,
  output logic              leak_en_o,
  input  logic              fire_i,
  input  logic              out_full_i,
  output logic              out_push_o,
  output logic [POST_W-1:0] out_data_o,
  output logic              busy_o,
  output logic              step_done_o,
  output logic [2:0]        state_o,
  output logic [STEP_W-1:0] step_cnt_o,
  output logic [POST_W:0]   spike_cnt_o,
  output logic [7:0]        drop_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ACCUM = 3'd2,
    S_LEAK  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [PRE_W-1:0]  pre_idx;
  logic [POST_W-1:0] post_idx;
  logic [STEP_W-1:0] step_cnt;
  logic [POST_W:0]   spike_cnt;
  logic [7:0]        drop_cnt;

  logic            in_ok;
  logic            pop_ok;
  logic            pop_drop;
  logic            post_last;
  logic            advance;
  logic [WA_W-1:0] w_addr;

  assign in_ok     = 32'(in_data_i) < N_PRE;
  assign pop_ok    = !in_empty_i && in_ok;
  assign pop_drop  = !in_empty_i && !in_ok;
  assign post_last = post_idx == POST_W'(N_POST - 1);
  // A firing neuron with nowhere to put its spike freezes LEAK.
  assign advance   = !(fire_i && out_full_i);
  assign w_addr    = WA_W'(pre_idx) * WA_W'(N_POST)
                   + WA_W'(post_idx);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start_i) state_nx = S_FETCH;
      S_FETCH: begin
        if (in_empty_i) state_nx = S_LEAK;
        else if (in_ok) state_nx = S_ACCUM;
      end
      S_ACCUM: if (post_last) state_nx = S_FETCH;
      S_LEAK:  if (advance && post_last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_idx   <= '0;
      post_idx  <= '0;
      step_cnt  <= '0;
      spike_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            spike_cnt <= '0;
            pre_idx   <= '0;
            post_idx  <= '0;
          end
        end
        S_FETCH: begin
          unique case (1'b1)
            in_empty_i: post_idx <= '0;
            pop_ok: begin
              pre_idx  <= in_data_i;
              post_idx <= '0;
            end
            pop_drop: begin
              if (drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
            end
            default: ;
          endcase
        end
        S_ACCUM: begin
          post_idx <= post_last ? '0 : post_idx + 1'b1;
        end
        S_LEAK: begin
          if (advance) begin
            post_idx <= post_last ? '0 : post_idx + 1'b1;
            if (fire_i) spike_cnt <= spike_cnt + 1'b1;
          end
        end
        S_DONE:  step_cnt <= step_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Strobes are masked during reset so nothing leaks out
  // of a half-finished step on the reset cycle.
  always_comb begin
    in_rd_o     = 1'b0;
    acc_en_o    = 1'b0;
    leak_en_o   = 1'b0;
    out_push_o  = 1'b0;
    out_data_o  = '0;
    step_done_o = 1'b0;
    w_addr_o    = '0;
    n_addr_o    = '0;
    if (!rst_i) begin
      unique case (state)
        S_FETCH: in_rd_o = !in_empty_i;
        S_ACCUM: begin
          acc_en_o = 1'b1;
          w_addr_o = w_addr;
          n_addr_o = post_idx;
        end
        S_LEAK: begin
          n_addr_o   = post_idx;
          leak_en_o  = advance;
          out_push_o = advance && fire_i;
          if (advance && fire_i) out_data_o = post_idx;
        end
        S_DONE:  step_done_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign busy_o      = state != S_IDLE;
  assign state_o     = state;
  assign step_cnt_o  = step_cnt;
  assign spike_cnt_o = spike_cnt;
  assign drop_cnt_o  = drop_cnt;

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Directed bench for lif_step_scheduler with a FIFO model
// and scoreboard queues of expected datapath events.
module tb_lif_step_scheduler;

  localparam int N_PRE  = 20;
  localparam int N_POST = 10;
  localparam int STEP_W = 16;
  localparam int PRE_W  = 5;
  localparam int POST_W = 4;
  localparam int WA_W   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_i;
  logic              start_i;
  logic              in_empty;
  logic [PRE_W-1:0]  in_data;
  logic              in_rd_o;
  logic [WA_W-1:0]   w_addr_o;
  logic [POST_W-1:0] n_addr_o;
  logic              acc_en_o;
  logic              leak_en_o;
  logic              fire_i;
  logic              out_full;
  logic              out_push_o;
  logic [POST_W-1:0] out_data_o;
  logic              busy_o;
  logic              step_done_o;
  logic [2:0]        state_o;
  logic [STEP_W-1:0] step_cnt_o;
  logic [POST_W:0]   spike_cnt_o;
  logic [7:0]        drop_cnt_o;

  int fifo[$];
  int exp_acc[$];
  int exp_leak[$];
  int exp_push[$];
  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int full_budget = 0;
  int fire_idx = -1;

  assign fire_i = (fire_idx >= 0) && (state_o == 3'd3)
               && (int'(n_addr_o) == fire_idx);
  assign out_full = full_budget != 0;

  lif_step_scheduler #(
    .N_PRE (N_PRE),
    .N_POST(N_POST),
    .STEP_W(STEP_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .in_empty_i (in_empty),
    .in_data_i  (in_data),
    .in_rd_o    (in_rd_o),
    .w_addr_o   (w_addr_o),
    .n_addr_o   (n_addr_o),
    .acc_en_o   (acc_en_o),
    .leak_en_o  (leak_en_o),
    .fire_i     (fire_i),
    .out_full_i (out_full),
    .out_push_o (out_push_o),
    .out_data_o (out_data_o),
    .busy_o     (busy_o),
    .step_done_o(step_done_o),
    .state_o    (state_o),
    .step_cnt_o (step_cnt_o),
    .spike_cnt_o(spike_cnt_o),
    .drop_cnt_o (drop_cnt_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic fifo_sync();
    in_empty = fifo.size() == 0;
    if (in_empty) in_data = '0;
    else          in_data = PRE_W'(fifo[0]);
  endtask

  task automatic expect_acc(input int p);
    for (int j = 0; j < N_POST; j++)
      exp_acc.push_back(p * N_POST + j);
  endtask

  task automatic expect_leak();
    for (int j = 0; j < N_POST; j++)
      exp_leak.push_back(j);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_state"}, state_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_rd"}, in_rd_o, 0);
    check({tag, "_acc"}, acc_en_o, 0);
    check({tag, "_leak"}, leak_en_o, 0);
    check({tag, "_push"}, out_push_o, 0);
    check({tag, "_done"}, step_done_o, 0);
    check({tag, "_waddr"}, w_addr_o, 0);
    check({tag, "_naddr"}, n_addr_o, 0);
    check({tag, "_steps"}, step_cnt_o, 0);
    check({tag, "_spikes"}, spike_cnt_o, 0);
    check({tag, "_drops"}, drop_cnt_o, 0);
  endtask

  task automatic observe();
    int e;
    check("acc_leak_excl", acc_en_o & leak_en_o, 0);
    check("rd_when_empty", in_rd_o & in_empty, 0);
    if (in_rd_o) rd_cnt++;
    if (fire_i && out_full) begin
      check("stall_leak", leak_en_o, 0);
      check("stall_push", out_push_o, 0);
    end
    if (acc_en_o) begin
      if (exp_acc.size() == 0) check("acc_extra", acc_en_o, 0);
      else begin
        e = exp_acc.pop_front();
        check("acc_w_addr", w_addr_o, e);
        check("acc_n_addr", n_addr_o, e % N_POST);
      end
    end
    if (leak_en_o) begin
      if (exp_leak.size() == 0) check("leak_extra", leak_en_o, 0);
      else check("leak_n_addr", n_addr_o, exp_leak.pop_front());
    end
    if (out_push_o) begin
      if (exp_push.size() == 0) check("push_extra", out_push_o, 0);
      else check("push_data", out_data_o, exp_push.pop_front());
    end
  endtask

  // Called just after a negedge with the DUT in IDLE.
  // Returns just after a negedge with the DUT back in IDLE.
  task automatic run_step(input bit hold, input int exp_done,
                          input int exp_steps, input int exp_spk,
                          input int exp_drop, input int exp_rd);
    int cyc;
    bit done;
    bit rd;
    bit stall;
    check("idle_pre", state_o, 0);
    rd_cnt = 0;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = hold;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      observe();
      rd = in_rd_o;
      stall = fire_i && out_full;
      if (step_done_o) begin
        done = 1'b1;
        check("done_cycle", cyc, exp_done);
      end else begin
        @(posedge clk);
        #1;
        if (rd) begin
          void'(fifo.pop_front());
          fifo_sync();
        end
        if (stall) full_budget--;
      end
    end
    if (!done) check("done_timeout", step_done_o, 1);
    @(negedge clk);
    check("idle_post", state_o, 0);
    check("busy_post", busy_o, 0);
    check("step_cnt", step_cnt_o, exp_steps);
    check("spike_cnt", spike_cnt_o, exp_spk);
    check("drop_cnt", drop_cnt_o, exp_drop);
    check("rd_pulses", rd_cnt, exp_rd);
    check("acc_left", exp_acc.size(), 0);
    check("leak_left", exp_leak.size(), 0);
    check("push_left", exp_push.size(), 0);
  endtask

  initial begin
    bit found;
    bit rd;
    rst_i = 1'b1;
    start_i = 1'b0;
    fifo = '{3, 7};
    fifo_sync();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("rd_after_reset", in_rd_o, 0);
    check("idle_after_reset", state_o, 0);

    // two valid spikes {3,7}
    expect_acc(3);
    expect_acc(7);
    expect_leak();
    run_step(1'b0, 34, 1, 0, 0, 2);

    // empty FIFO
    expect_leak();
    run_step(1'b0, 12, 2, 0, 0, 0);

    // out-of-range index dropped
    fifo = '{20};
    fifo_sync();
    expect_leak();
    run_step(1'b0, 13, 3, 0, 1, 1);

    // neuron 4 fires into a full FIFO for 3 cycles
    fire_idx = 4;
    full_budget = 3;
    expect_leak();
    exp_push.push_back(4);
    run_step(1'b0, 15, 4, 1, 1, 0);
    check("stall_budget", full_budget, 0);
    fire_idx = -1;

    // start held high across two back-to-back steps
    expect_leak();
    run_step(1'b1, 12, 5, 0, 1, 0);
    expect_leak();
    run_step(1'b1, 12, 6, 0, 1, 0);
    start_i = 1'b0;
    @(negedge clk);

    // reset in the middle of ACCUM at post_idx 5
    fifo = '{3, 7};
    fifo_sync();
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (acc_en_o && n_addr_o == 4'd5) found = 1'b1;
      else begin
        rd = in_rd_o;
        @(posedge clk);
        #1;
        if (rd) begin
          void'(fifo.pop_front());
          fifo_sync();
        end
      end
    end
    check("rst_found_acc", acc_en_o, 1);
    check("rst_found_waddr", w_addr_o, 35);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check_quiet("midrst");
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("rd_after_midrst", in_rd_o, 0);
    check("fifo_kept", fifo.size(), 1);

    // clean step with the remaining entry {7}
    expect_acc(7);
    expect_leak();
    run_step(1'b0, 23, 1, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
